// File: rtl/mouse_quadrature.sv
// Turns relative mouse reports into rate-limited Gray-code quadrature and button
// lines for the ikbd joystick0 port, replaying accumulated motion one step per tick.
module mouse_quadrature #(
    parameter int STEP_DIV = 500,
    parameter int ACC_W    = 10
) (
    input  logic              clk,
    input  logic              res,
    input  logic              strobe,
    input  logic signed [7:0] dx,
    input  logic signed [7:0] dy,
    input  logic        [1:0] buttons,
    output logic        [5:0] mouse,
    output logic              busy
);

    localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);
    localparam logic signed [ACC_W:0] SUM_MAX = (ACC_W + 1)'(2 ** (ACC_W - 1) - 1);
    localparam logic signed [ACC_W:0] SUM_MIN = -SUM_MAX;
    localparam logic signed [ACC_W:0] SUM_ONE = (ACC_W + 1)'(1);

    typedef enum logic [1:0] {
        STEP_NONE = 2'b00,
        STEP_FWD  = 2'b01,
        STEP_REV  = 2'b11
    } step_e;

    logic [CNT_W-1:0]        r_tick_cnt;
    logic signed [ACC_W-1:0] r_acc_x;
    logic signed [ACC_W-1:0] r_acc_y;
    logic [1:0]              r_ph_x;     // {A, B}
    logic [1:0]              r_ph_y;     // {A, B}
    logic [1:0]              r_btn;
    logic                    r_busy;

    logic                    w_tick;
    step_e                   w_step_x;
    step_e                   w_step_y;
    logic signed [ACC_W-1:0] w_acc_x_nxt;
    logic signed [ACC_W-1:0] w_acc_y_nxt;

    // Direction is taken from the accumulator before any strobe in the same cycle lands.
    function automatic step_e step_dir(input logic tick, input logic signed [ACC_W-1:0] acc);
        step_dir = STEP_NONE;
        if (tick && (acc != '0)) begin
            step_dir = acc[ACC_W-1] ? STEP_REV : STEP_FWD;
        end
    endfunction

    function automatic logic signed [ACC_W-1:0] acc_update(
        input logic signed [ACC_W-1:0] acc,
        input logic signed [7:0]       delta,
        input logic                    add,
        input step_e                   step
    );
        logic signed [ACC_W:0] sum;
        sum = {acc[ACC_W-1], acc};
        if (add) begin
            sum = sum + {{(ACC_W - 7){delta[7]}}, delta};
        end
        case (step)
            STEP_FWD: sum = sum - SUM_ONE;
            STEP_REV: sum = sum + SUM_ONE;
            default:  sum = sum;
        endcase
        if (sum > SUM_MAX) begin
            acc_update = SUM_MAX[ACC_W-1:0];
        end else if (sum < SUM_MIN) begin
            acc_update = SUM_MIN[ACC_W-1:0];
        end else begin
            acc_update = sum[ACC_W-1:0];
        end
    endfunction

    // Forward walks 00->01->11->10, reverse walks it backwards; one bit flips per step.
    function automatic logic [1:0] phase_next(input logic [1:0] ph, input step_e step);
        case (step)
            STEP_FWD: phase_next = {ph[0], ~ph[1]};
            STEP_REV: phase_next = {~ph[0], ph[1]};
            default:  phase_next = ph;
        endcase
    endfunction

    assign w_tick      = (r_tick_cnt == CNT_LAST);
    assign w_step_x    = step_dir(w_tick, r_acc_x);
    assign w_step_y    = step_dir(w_tick, r_acc_y);
    assign w_acc_x_nxt = acc_update(r_acc_x, dx, strobe, w_step_x);
    assign w_acc_y_nxt = acc_update(r_acc_y, dy, strobe, w_step_y);

    // NOTE: reset is synchronous, so it also wins over a strobe sampled on the same edge.
    always_ff @(posedge clk) begin
        if (res) begin
            r_tick_cnt <= '0;
            r_acc_x    <= '0;
            r_acc_y    <= '0;
            r_ph_x     <= 2'b00;
            r_ph_y     <= 2'b00;
            r_btn      <= 2'b00;
            r_busy     <= 1'b0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + CNT_W'(1);
            r_acc_x    <= w_acc_x_nxt;
            r_acc_y    <= w_acc_y_nxt;
            r_ph_x     <= phase_next(r_ph_x, w_step_x);
            r_ph_y     <= phase_next(r_ph_y, w_step_y);
            if (strobe) begin
                r_btn <= buttons;
            end
            r_busy     <= (w_acc_x_nxt != '0) || (w_acc_y_nxt != '0);
        end
    end

    assign mouse = {r_btn, r_ph_y[0], r_ph_y[1], r_ph_x[0], r_ph_x[1]};
    assign busy  = r_busy;

endmodule

// File: tb/tb_mouse_quadrature.sv
// Directed bench for mouse_quadrature: reset, stepping, reversal, saturation,
// strobe/tick coincidence and button latching, against a small phase model.
module tb_mouse_quadrature;

    localparam int DIV = 20;

    logic              clk = 1'b0;
    logic              res;
    logic              strobe;
    logic signed [7:0] dx;
    logic signed [7:0] dy;
    logic        [1:0] buttons;
    logic        [5:0] mouse;
    logic              busy;

    int         n_checks = 0;
    int         n_errors = 0;
    int         edges;
    logic [1:0] exp_x;
    logic [1:0] exp_y;
    logic [1:0] exp_btn;

    mouse_quadrature #(.STEP_DIV(DIV), .ACC_W(10)) dut (
        .clk     (clk),
        .res     (res),
        .strobe  (strobe),
        .dx      (dx),
        .dy      (dy),
        .buttons (buttons),
        .mouse   (mouse),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Non-reset edges since the last reset; a step lands on every multiple of DIV.
    always @(posedge clk) begin
        if (res) edges <= 0;
        else     edges <= edges + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] gfwd(input logic [1:0] ph);
        case (ph)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] grev(input logic [1:0] ph);
        case (ph)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // mouse = {right, left, YB, YA, XB, XA}; exp_x/exp_y hold (A,B).
    function automatic logic [5:0] model_mouse();
        return {exp_btn, exp_y[0], exp_y[1], exp_x[0], exp_x[1]};
    endfunction

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic signed [7:0] vx, input logic signed [7:0] vy, input logic [1:0] vb);
        strobe  = 1'b1;
        dx      = vx;
        dy      = vy;
        buttons = vb;
        step_clk();
        strobe  = 1'b0;
        dx      = '0;
        dy      = '0;
    endtask

    // Advance to just after the next tick edge; outputs must not move before it.
    task automatic to_tick(input string tag);
        logic [5:0] m0;
        logic       early;
        int         n;
        m0    = mouse;
        early = 1'b0;
        n     = 0;
        do begin
            step_clk();
            n++;
            if ((edges % DIV != 0) && (mouse !== m0)) early = 1'b1;
        end while ((edges % DIV != 0) && (n <= DIV));
        check(tag, 32'({early, n > DIV}), 32'd0);
    endtask

    initial begin
        logic act;
        int   n;

        exp_x = 2'b00; exp_y = 2'b00; exp_btn = 2'b00;

        // Reset held while strobing motion and buttons.
        res = 1'b1; strobe = 1'b1; dx = 8'sd5; dy = 8'sd5; buttons = 2'b11;
        step_clk();
        check("rst_c1_mouse", 32'(mouse), 32'd0);
        check("rst_c1_busy", 32'(busy), 32'd0);
        step_clk();
        check("rst_c2_mouse", 32'(mouse), 32'd0);
        check("rst_c2_busy", 32'(busy), 32'd0);
        res = 1'b0; strobe = 1'b0; dx = '0; dy = '0; buttons = 2'b00;
        act = 1'b0;
        repeat (DIV + 2) begin
            step_clk();
            if ((mouse !== 6'd0) || (busy !== 1'b0)) act = 1'b1;
        end
        check("rst_idle", 32'(act), 32'd0);

        // Single X strobe of +3: 01, 11, 10.
        send(8'sd3, 8'sd0, 2'b00);
        check("x_busy_set", 32'(busy), 32'd1);
        check("x_no_step_yet", 32'(mouse), 32'(model_mouse()));
        for (int i = 0; i < 3; i++) begin
            to_tick("x_rate");
            exp_x = gfwd(exp_x);
            check("x_phase", 32'(mouse), 32'(model_mouse()));
            check("x_busy", 32'(busy), 32'(i < 2));
        end
        to_tick("x_idle_rate");
        check("x_idle_hold", 32'(mouse), 32'(model_mouse()));

        // Y negative, then reversal.
        send(8'sd0, -8'sd2, 2'b00);
        for (int i = 0; i < 2; i++) begin
            to_tick("yneg_rate");
            exp_y = grev(exp_y);
            check("yneg_phase", 32'(mouse), 32'(model_mouse()));
            check("yneg_busy", 32'(busy), 32'(i < 1));
        end
        send(8'sd0, 8'sd1, 2'b00);
        check("yrev_busy_set", 32'(busy), 32'd1);
        to_tick("yrev_rate");
        exp_y = gfwd(exp_y);
        check("yrev_phase", 32'(mouse), 32'(model_mouse()));
        check("yrev_busy", 32'(busy), 32'd0);
        to_tick("yrev_idle_rate");
        check("yrev_idle_hold", 32'(mouse), 32'(model_mouse()));

        // Saturation: 5 x +127 back-to-back clamps at +511.
        repeat (5) send(8'sd127, 8'sd0, 2'b00);
        check("sat_busy_set", 32'(busy), 32'd1);
        for (int i = 0; i < 511; i++) begin
            to_tick("sat_rate");
            exp_x = gfwd(exp_x);
            check("sat_step", 32'(mouse), 32'(model_mouse()));
            if (i == 509) check("sat_busy_before_last", 32'(busy), 32'd1);
        end
        check("sat_busy_end", 32'(busy), 32'd0);
        to_tick("sat_extra_rate");
        check("sat_no_extra_step", 32'(mouse), 32'(model_mouse()));

        // dx = -128 replays 128 reverse steps.
        send(8'sh80, 8'sd0, 2'b00);
        for (int i = 0; i < 128; i++) begin
            to_tick("neg128_rate");
            exp_x = grev(exp_x);
            check("neg128_step", 32'(mouse), 32'(model_mouse()));
        end
        check("neg128_busy_end", 32'(busy), 32'd0);
        to_tick("neg128_extra_rate");
        check("neg128_no_extra_step", 32'(mouse), 32'(model_mouse()));

        // Strobe of +2 landing on the tick edge with acc_x = 1.
        send(8'sd1, 8'sd0, 2'b00);
        n = 0;
        while ((edges % DIV != DIV - 1) && (n < 2 * DIV)) begin
            step_clk();
            n++;
        end
        check("coin_align", 32'(edges % DIV), 32'(DIV - 1));
        send(8'sd2, 8'sd0, 2'b00);
        exp_x = gfwd(exp_x);
        check("coin_step", 32'(mouse), 32'(model_mouse()));
        check("coin_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 2; i++) begin
            to_tick("coin_rate");
            exp_x = gfwd(exp_x);
            check("coin_follow", 32'(mouse), 32'(model_mouse()));
            check("coin_follow_busy", 32'(busy), 32'(i < 1));
        end
        to_tick("coin_extra_rate");
        check("coin_no_extra_step", 32'(mouse), 32'(model_mouse()));

        // Buttons: one-cycle latency, held between strobes.
        buttons = 2'b01;
        step_clk();
        check("btn_no_strobe", 32'(mouse), 32'(model_mouse()));
        send(8'sd0, 8'sd0, 2'b01);
        exp_btn = 2'b01;
        check("btn_left", 32'(mouse), 32'(model_mouse()));
        send(8'sd0, 8'sd0, 2'b10);
        exp_btn = 2'b10;
        check("btn_right", 32'(mouse), 32'(model_mouse()));
        buttons = 2'b11;
        repeat (1000) step_clk();
        check("btn_hold", 32'(mouse), 32'(model_mouse()));

        // Reset with motion pending and a simultaneous strobe discards everything.
        send(8'sd50, -8'sd50, 2'b10);
        res = 1'b1; strobe = 1'b1; dx = 8'sd5; dy = 8'sd5; buttons = 2'b11;
        step_clk();
        res = 1'b0; strobe = 1'b0; dx = '0; dy = '0; buttons = 2'b00;
        check("rst2_mouse", 32'(mouse), 32'd0);
        check("rst2_busy", 32'(busy), 32'd0);
        act = 1'b0;
        repeat (DIV + 2) begin
            step_clk();
            if ((mouse !== 6'd0) || (busy !== 1'b0)) act = 1'b1;
        end
        check("rst2_idle", 32'(act), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mouse_quadrature.md
Name: mouse_quadrature

Overview:
- Converts relative mouse reports (signed dx/dy deltas plus two buttons) into the quadrature and button lines the ikbd samples on its joystick0 input.
- Sits directly upstream of the ikbd, between the host/USB HID side and the HD6301 port inputs. Its 6-bit output connects straight to joystick0.
- Accumulates incoming motion and replays it as rate-limited Gray-code steps so the 6301 firmware never misses an edge.

Parameters:
- STEP_DIV, 500, clk cycles between quadrature steps (2 MHz / 500 = 4 kHz per axis).
- ACC_W, 10, width of each signed per-axis motion accumulator.

Ports:
- clk  in  1  system clock (2 MHz ikbd clock domain).
- res  in  1  reset; synchronous, active-high.
- strobe  in  1  one-cycle pulse: dx, dy and buttons are valid this cycle.
- dx  in  8  signed X delta; positive means right.
- dy  in  8  signed Y delta; positive means down.
- buttons  in  2  [0]=left, [1]=right, active-high.
- mouse  out  6  [0]=XA, [1]=XB, [2]=YA, [3]=YB, [4]=left button, [5]=right button; active-high (ikbd inverts).
- busy  out  1  high while either accumulator is non-zero.

Behaviour:
- Reset (res high at a clk edge):
  - both accumulators = 0, both phases = 00, button register = 00, tick counter = 0.
  - mouse = 6'b000000, busy = 0.
  - res overrides a strobe in the same cycle; pending motion is discarded.
- Tick counter:
  - free-running 0..STEP_DIV-1; tick is asserted for one cycle when the count equals STEP_DIV-1, then the count wraps to 0.
  - Counts regardless of whether motion is pending.
- Buttons:
  - on strobe, the button register loads buttons; it drives mouse[5:4] from the next cycle (1-cycle latency).
  - The register holds its value between strobes.
- Per-axis accumulator (X and Y are identical and independent), evaluated every cycle:
  - step = +1 if tick and acc > 0; -1 if tick and acc < 0; 0 otherwise.
  - acc_next = sat(acc + (strobe ? sext(delta) : 0) - step).
  - sat clamps to [-(2^(ACC_W-1)-1), +(2^(ACC_W-1)-1)], i.e. ±511 at the defaults. Compute the sum one bit wider than ACC_W before clamping.
  - A strobe in the same cycle as a tick applies both; the step direction is decided from the pre-update acc.
- Quadrature phase, a 2-bit Gray counter per axis driving (A,B):
  - step +1 advances 00→01→11→10→00.
  - step -1 moves in reverse: 00→10→11→01→00.
  - Output changes exactly one cycle after the tick edge.
  - Only one bit changes per step; the phase persists at its last value when idle (it does not return to 00).
- Step rate: at most one step per axis per STEP_DIV cycles; X and Y may step in the same tick.
- busy = (acc_x != 0) | (acc_y != 0), registered and updated with the accumulators.
- Reversal: if the sign of acc flips after a strobe, the next tick steps in the new direction from the current phase. No reset of phase is needed.
- dx = -128 is valid; it sign-extends and accumulates like any other value.

Test Plan:
- Reset behaviour: assert res for 2 cycles while strobing dx=5, dy=5, buttons=11 → mouse=000000 and busy=0 throughout; after release and STEP_DIV+2 cycles there is still no quadrature activity.
- Single X strobe: strobe dx=+3, dy=0 → over the next 3 ticks (XA,XB) goes 01, 11, 10, one step per 500 cycles; (YA,YB) stays 00; busy falls the cycle after the third step.
- Negative Y, then reversal: strobe dy=-2 → (YA,YB) goes 10, 11. Then strobe dy=+1 → next tick gives 10; busy=0 afterwards.
- Saturation: strobe dx=+127 five times back-to-back (635 requested) → acc_x clamps to 511; exactly 511 forward steps follow, then busy=0.
- Strobe coincident with tick: with acc_x=1, strobe dx=+2 in the tick cycle → one step issued and acc_x=2; exactly 2 further steps follow.
- Buttons: strobe buttons=01 → mouse[4]=1 the next cycle; strobe buttons=10 → mouse[5:4]=10; the register holds across 1000 idle cycles.
